priority_encoder_8to3: RTL

Registered 8-to-3 priority encoder with a valid/ack handshake. It is the inverse of the team's 3-to-8 decoder: it collapses 8 request lines into a 3-bit binary index (bit k maps to code k, so 8'h01 gives 3'b000 and 8'h80 gives 3'b111). Requests are latched into a pending register and served one at a time, highest index first. The consumer acknowledges each code, which retires that request. Intended as the request-side front end ahead of the decoder in the assignment datapath.

---
 rtl/priority_encoder_8to3_if.sv | 23 ++
 rtl/priority_encoder_8to3.sv | 92 +++++++++
 2 files changed

// File: rtl/priority_encoder_8to3_if.sv
// Request/serve bus between a requester/consumer and the 8-to-3 priority
// encoder. The encoder sits on the slave side.
interface priority_encoder_8to3_if;
  logic [7:0] d;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       ack;
  logic [2:0] q;
  logic       valid;
  logic [7:0] pending;
  logic [7:0] mask;
  logic       overflow;

  modport master (
    output d, mask_we, mask_wdata, ack,
    input  q, valid, pending, mask, overflow
  );

  modport slave (
    input  d, mask_we, mask_wdata, ack,
    output q, valid, pending, mask, overflow
  );
endinterface

// File: rtl/priority_encoder_8to3.sv
// Registered 8-to-3 priority encoder with valid/ack handshake.
// Request pulses accumulate in a pending register. The highest enabled
// pending line is served as a 3-bit code. The code is held until acked,
// and the ack retires that line.
module priority_encoder_8to3 #(
  parameter logic [7:0] MASK_RESET = 8'hFF
) (
  input logic                   clk,
  input logic                   reset_n,
  priority_encoder_8to3_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] mask_q, mask_d;
  logic [2:0] q_q, q_d;
  logic       overflow_q, overflow_d;

  logic [7:0] clr;
  logic [7:0] req;
  logic [2:0] sel;

  // Index of the highest set bit; 0 when nothing is set (caller guards).
  function automatic logic [2:0] highest_idx(input logic [7:0] v);
    highest_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) highest_idx = 3'(i);
    end
  endfunction

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    onehot8 = 8'b1 << idx;
  endfunction

  // Pending/mask/overflow next-state; selection reads the registered values.
  always_comb begin
    clr        = (state_q == HOLD && bus.ack) ? onehot8(q_q) : 8'h00;
    req        = pending_q & mask_q;
    sel        = highest_idx(req);
    // A new request on the line being retired wins and is not an overflow.
    pending_d  = (pending_q & ~clr) | bus.d;
    overflow_d = |(bus.d & pending_q & ~clr);
    mask_d     = bus.mask_we ? bus.mask_wdata : mask_q;
  end

  // Serve FSM: load a code in IDLE, freeze it in HOLD until acked.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          q_d     = sel;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pending_q  <= 8'h00;
      mask_q     <= MASK_RESET;
      q_q        <= 3'b000;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      q_q        <= q_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.q        = q_q;
  assign bus.valid    = (state_q == HOLD);
  assign bus.pending  = pending_q;
  assign bus.mask     = mask_q;
  assign bus.overflow = overflow_q;

endmodule
